// File: rtl/note_judge.sv
// Note window judge: compares player key edges against the song engine's current
// note and keeps saturating score, combo and best combo with one-cycle judgement pulses.
module note_judge #(
    parameter int SETTLE      = 2,
    parameter int PERFECT_PTS = 3,
    parameter int GOOD_PTS    = 1
) (
    input  logic        game_clock,
    input  logic        game_reset_n,
    input  logic [7:0]  game_frame,
    input  logic [11:0] curr_note,
    input  logic [3:0]  hold_length,
    input  logic [11:0] keys,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic [7:0]  max_combo,
    output logic        hit_pulse,
    output logic        perfect_pulse,
    output logic        miss_pulse
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SETTLE_WAIT = 2'd1,
        ARMED       = 2'd2,
        DONE        = 2'd3
    } state_t;

    localparam logic [2:0]  SETTLE_LAST = 3'(SETTLE - 1);
    localparam logic [15:0] PERFECT_INC = 16'(PERFECT_PTS);
    localparam logic [15:0] GOOD_INC    = 16'(GOOD_PTS);

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] a);
        return (a == 8'hFF) ? 8'hFF : (a + 8'd1);
    endfunction

    state_t      state_r, state_next_s;
    logic [7:0]  prev_frame_r;
    logic [11:0] prev_keys_r;
    logic [11:0] target_r, target_next_s;
    logic [3:0]  len_r, len_next_s;
    logic [3:0]  remaining_r, remaining_next_s;
    logic [2:0]  settle_cnt_r, settle_next_s;
    logic [15:0] score_r, score_next_s;
    logic [7:0]  combo_r, combo_next_s;
    logic [7:0]  max_combo_r, max_next_s;
    logic        hit_r, perfect_r, miss_r;
    logic        hit_s, perfect_s, miss_s;

    logic        frame_tick_s, restart_s, close_s, wrong_s, right_s;
    logic [11:0] key_rise_s;
    logic [3:0]  note_len_s;
    logic [7:0]  combo_inc_s;

    assign frame_tick_s = (game_frame != prev_frame_r);
    assign restart_s    = frame_tick_s && (game_frame == 8'd0);
    assign close_s      = frame_tick_s && (remaining_r == 4'd1);
    assign key_rise_s   = keys & ~prev_keys_r;
    assign wrong_s      = ((key_rise_s & ~target_r) != 12'd0);
    assign right_s      = ((key_rise_s & target_r) != 12'd0);
    assign note_len_s   = (hold_length == 4'd0) ? 4'd1 : hold_length;
    assign combo_inc_s  = sat_inc8(combo_r);

    // Window state machine, judgement and score/combo update; a hit is judged before a window close
    always_comb begin
        state_next_s     = state_r;
        settle_next_s    = settle_cnt_r;
        target_next_s    = target_r;
        len_next_s       = len_r;
        remaining_next_s = remaining_r;
        score_next_s     = score_r;
        combo_next_s     = combo_r;
        max_next_s       = max_combo_r;
        hit_s            = 1'b0;
        perfect_s        = 1'b0;
        miss_s           = 1'b0;
        if (restart_s) begin
            state_next_s  = SETTLE_WAIT;
            settle_next_s = 3'd0;
            score_next_s  = 16'd0;
            combo_next_s  = 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (frame_tick_s) begin
                        state_next_s  = SETTLE_WAIT;
                        settle_next_s = 3'd0;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                SETTLE_WAIT: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        target_next_s    = curr_note;
                        len_next_s       = note_len_s;
                        remaining_next_s = note_len_s;
                        settle_next_s    = 3'd0;
                        state_next_s     = (curr_note == 12'd0) ? DONE : ARMED;
                    end else begin
                        settle_next_s = settle_cnt_r + 3'd1;
                    end
                end
                ARMED: begin
                    if (wrong_s) begin
                        miss_s       = 1'b1;
                        state_next_s = DONE;
                    end else if (right_s) begin
                        hit_s        = 1'b1;
                        perfect_s    = (remaining_r == len_r);
                        state_next_s = DONE;
                    end else begin
                        state_next_s = ARMED;
                    end
                    if (close_s) begin
                        miss_s        = ~hit_s;
                        state_next_s  = SETTLE_WAIT;
                        settle_next_s = 3'd0;
                    end else if (frame_tick_s) begin
                        remaining_next_s = remaining_r - 4'd1;
                    end else begin
                        remaining_next_s = remaining_r;
                    end
                end
                DONE: begin
                    if (close_s) begin
                        state_next_s  = SETTLE_WAIT;
                        settle_next_s = 3'd0;
                    end else if (frame_tick_s) begin
                        remaining_next_s = remaining_r - 4'd1;
                    end else begin
                        state_next_s = DONE;
                    end
                end
                default: begin
                    state_next_s  = IDLE;
                    settle_next_s = 3'd0;
                end
            endcase
            if (hit_s) begin
                combo_next_s = combo_inc_s;
                max_next_s   = (combo_inc_s > max_combo_r) ? combo_inc_s : max_combo_r;
                score_next_s = sat_add16(score_r, perfect_s ? PERFECT_INC : GOOD_INC);
            end else if (miss_s) begin
                combo_next_s = 8'd0;
            end else begin
                combo_next_s = combo_r;
            end
        end
    end

    // State, history and registered outputs
    always_ff @(posedge game_clock or negedge game_reset_n) begin
        if (!game_reset_n) begin
            state_r      <= IDLE;
            prev_frame_r <= 8'd0;
            prev_keys_r  <= 12'd0;
            target_r     <= 12'd0;
            len_r        <= 4'd0;
            remaining_r  <= 4'd0;
            settle_cnt_r <= 3'd0;
            score_r      <= 16'd0;
            combo_r      <= 8'd0;
            max_combo_r  <= 8'd0;
            hit_r        <= 1'b0;
            perfect_r    <= 1'b0;
            miss_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            prev_frame_r <= game_frame;
            prev_keys_r  <= keys;
            target_r     <= target_next_s;
            len_r        <= len_next_s;
            remaining_r  <= remaining_next_s;
            settle_cnt_r <= settle_next_s;
            score_r      <= score_next_s;
            combo_r      <= combo_next_s;
            max_combo_r  <= max_next_s;
            hit_r        <= hit_s;
            perfect_r    <= perfect_s;
            miss_r       <= miss_s;
        end
    end

    assign score         = score_r;
    assign combo         = combo_r;
    assign max_combo     = max_combo_r;
    assign hit_pulse     = hit_r;
    assign perfect_pulse = perfect_r;
    assign miss_pulse    = miss_r;

endmodule

// File: tb/tb_note_judge.sv
// Bench for note_judge: table of note windows with hand-derived results, directed
// corner sequences, then random windows scored by a window-level reference model.
module tb_note_judge;

    localparam int FRAME_LEN = 8;

    logic        game_clock;
    logic        game_reset_n;
    logic [7:0]  game_frame;
    logic [11:0] curr_note;
    logic [3:0]  hold_length;
    logic [11:0] keys;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic        hit_pulse;
    logic        perfect_pulse;
    logic        miss_pulse;

    int checks   = 0;
    int failures = 0;
    int n_hit    = 0;
    int n_perf   = 0;
    int n_miss   = 0;
    logic [7:0] frame_cnt;

    int m_score, m_combo, m_max, m_hit, m_perf, m_miss;
    int base_hit, base_perf, base_miss;

    typedef struct {
        logic [11:0] note;
        logic [3:0]  hold;
        logic [11:0] p0;
        logic [11:0] p1;
        bit          twice;
        int          d_hit;
        int          d_perf;
        int          d_miss;
        logic [15:0] exp_score;
        logic [7:0]  exp_combo;
        logic [7:0]  exp_max;
    } vec_t;

    vec_t vt [13];

    note_judge dut (
        .game_clock    (game_clock),
        .game_reset_n  (game_reset_n),
        .game_frame    (game_frame),
        .curr_note     (curr_note),
        .hold_length   (hold_length),
        .keys          (keys),
        .score         (score),
        .combo         (combo),
        .max_combo     (max_combo),
        .hit_pulse     (hit_pulse),
        .perfect_pulse (perfect_pulse),
        .miss_pulse    (miss_pulse)
    );

    initial game_clock = 1'b0;
    always #5 game_clock = ~game_clock;

    always @(negedge game_clock) begin
        if (hit_pulse)     n_hit  <= n_hit + 1;
        if (perfect_pulse) n_perf <= n_perf + 1;
        if (miss_pulse)    n_miss <= n_miss + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge game_clock);
        #1;
    endtask

    task automatic snap();
        base_hit  = n_hit;
        base_perf = n_perf;
        base_miss = n_miss;
    endtask

    task automatic chk_deltas(input string tag, input int dh, input int dp, input int dm);
        chk({tag, ".hits"},     32'(n_hit - base_hit),   32'(dh));
        chk({tag, ".perfects"}, 32'(n_perf - base_perf), 32'(dp));
        chk({tag, ".misses"},   32'(n_miss - base_miss), 32'(dm));
    endtask

    task automatic chk_totals(input string tag, input int s, input int c, input int m);
        chk({tag, ".score"},     32'(score),     32'(s));
        chk({tag, ".combo"},     32'(combo),     32'(c));
        chk({tag, ".max_combo"}, 32'(max_combo), 32'(m));
    endtask

    // One song frame: note presented at the frame change, press at offset 4, optional re-press at 6
    task automatic do_frame(input logic [11:0] note, input logic [3:0] hold,
                            input logic [11:0] press, input bit twice);
        frame_cnt = frame_cnt + 8'd1;
        if (frame_cnt == 8'd0) frame_cnt = 8'd1;
        game_frame  = frame_cnt;
        curr_note   = note;
        hold_length = hold;
        for (int c = 0; c < FRAME_LEN; c++) begin
            case (c)
                4:       keys = press;
                6:       keys = twice ? press : 12'h000;
                default: keys = 12'h000;
            endcase
            step();
        end
    endtask

    task automatic model_hit(input bit perf);
        m_combo = (m_combo == 255) ? 255 : m_combo + 1;
        if (m_combo > m_max) m_max = m_combo;
        m_score = m_score + (perf ? 3 : 1);
        if (m_score > 65535) m_score = 65535;
        m_hit++;
        if (perf) m_perf++;
    endtask

    task automatic model_miss();
        m_combo = 0;
        m_miss++;
    endtask

    task automatic rand_window(input bit force_rest);
        logic [11:0] one;
        logic [11:0] note;
        logic [11:0] press;
        logic [3:0]  hold;
        int          len;
        int          mode;
        bit          judged;
        one    = 12'h001;
        note   = ($urandom_range(0, 5) == 0) ? 12'h000 : (one << $urandom_range(0, 11));
        hold   = 4'($urandom_range(0, 3));
        len    = (hold == 4'd0) ? 1 : int'(hold);
        judged = 1'b0;
        for (int k = 0; k < len; k++) begin
            mode = int'($urandom_range(0, 5));
            case (mode)
                2:       press = note;
                3:       press = one << $urandom_range(0, 11);
                4:       press = 12'($urandom_range(0, 4095));
                5:       press = note | (one << $urandom_range(0, 11));
                default: press = 12'h000;
            endcase
            do_frame(note, hold, press, 1'($urandom_range(0, 1)));
            if (!judged && note != 12'h000 && press != 12'h000) begin
                judged = 1'b1;
                if ((press & ~note) != 12'h000) model_miss();
                else model_hit(k == 0);
            end
        end
        if (!judged && note != 12'h000) model_miss();
        if (force_rest || $urandom_range(0, 1) == 1) begin
            do_frame(12'h000, 4'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), 1'b0);
            chk_totals("rand", m_score, m_combo, m_max);
            chk("rand.hits",     32'(n_hit - base_hit),   32'(m_hit));
            chk("rand.perfects", 32'(n_perf - base_perf), 32'(m_perf));
            chk("rand.misses",   32'(n_miss - base_miss), 32'(m_miss));
        end
    endtask

    initial begin
        vt[0]  = '{12'h000, 4'd1, 12'h000, 12'h000, 1'b0, 0, 0, 0, 16'd0,  8'd0, 8'd0};
        vt[1]  = '{12'h000, 4'd1, 12'h000, 12'h000, 1'b0, 0, 0, 0, 16'd0,  8'd0, 8'd0};
        vt[2]  = '{12'h001, 4'd1, 12'h001, 12'h000, 1'b0, 1, 1, 0, 16'd3,  8'd1, 8'd1};
        vt[3]  = '{12'h080, 4'd2, 12'h000, 12'h080, 1'b1, 1, 0, 0, 16'd4,  8'd2, 8'd2};
        vt[4]  = '{12'h200, 4'd1, 12'h204, 12'h000, 1'b0, 0, 0, 1, 16'd4,  8'd0, 8'd2};
        vt[5]  = '{12'h020, 4'd1, 12'h000, 12'h000, 1'b0, 0, 0, 1, 16'd4,  8'd0, 8'd2};
        vt[6]  = '{12'h001, 4'd1, 12'h001, 12'h000, 1'b0, 1, 1, 0, 16'd7,  8'd1, 8'd2};
        vt[7]  = '{12'h002, 4'd1, 12'h002, 12'h000, 1'b0, 1, 1, 0, 16'd10, 8'd2, 8'd2};
        vt[8]  = '{12'h004, 4'd1, 12'h004, 12'h000, 1'b0, 1, 1, 0, 16'd13, 8'd3, 8'd3};
        vt[9]  = '{12'h800, 4'd0, 12'h800, 12'h000, 1'b0, 1, 1, 0, 16'd16, 8'd4, 8'd4};
        vt[10] = '{12'h000, 4'd1, 12'h0FF, 12'h000, 1'b0, 0, 0, 0, 16'd16, 8'd4, 8'd4};
        vt[11] = '{12'h002, 4'd2, 12'h000, 12'h004, 1'b0, 0, 0, 1, 16'd16, 8'd0, 8'd4};
        vt[12] = '{12'h010, 4'd2, 12'h010, 12'h020, 1'b0, 1, 1, 0, 16'd19, 8'd1, 8'd4};

        game_reset_n = 1'b0;
        game_frame   = 8'd0;
        curr_note    = 12'h000;
        hold_length  = 4'd0;
        keys         = 12'h000;
        frame_cnt    = 8'd0;
        repeat (3) step();
        chk_totals("reset", 0, 0, 0);
        chk("reset.hit_pulse",     32'(hit_pulse),     32'd0);
        chk("reset.perfect_pulse", 32'(perfect_pulse), 32'd0);
        chk("reset.miss_pulse",    32'(miss_pulse),    32'd0);
        game_reset_n = 1'b1;
        step();

        for (int i = 0; i < 13; i++) begin
            int len;
            len = (vt[i].hold == 4'd0) ? 1 : int'(vt[i].hold);
            snap();
            for (int k = 0; k < len; k++)
                do_frame(vt[i].note, vt[i].hold,
                         (k == 0) ? vt[i].p0 : ((k == 1) ? vt[i].p1 : 12'h000), vt[i].twice);
            do_frame(12'h000, 4'd1, 12'h000, 1'b0);
            chk_deltas($sformatf("vec%0d", i), vt[i].d_hit, vt[i].d_perf, vt[i].d_miss);
            chk_totals($sformatf("vec%0d", i), int'(vt[i].exp_score),
                       int'(vt[i].exp_combo), int'(vt[i].exp_max));
        end

        // Back-to-back hits, then a hit landing on the very cycle that closes its window
        snap();
        do_frame(12'h001, 4'd1, 12'h001, 1'b0);
        do_frame(12'h002, 4'd1, 12'h002, 1'b0);
        do_frame(12'h004, 4'd1, 12'h004, 1'b0);
        do_frame(12'h008, 4'd1, 12'h008, 1'b0);
        do_frame(12'h010, 4'd1, 12'h000, 1'b0);
        frame_cnt   = frame_cnt + 8'd1;
        game_frame  = frame_cnt;
        curr_note   = 12'h000;
        hold_length = 4'd1;
        for (int c = 0; c < FRAME_LEN; c++) begin
            keys = (c == 0) ? 12'h010 : 12'h000;
            step();
        end
        chk_deltas("b2b", 5, 5, 0);
        chk_totals("b2b", 34, 6, 6);

        force dut.score_r = 16'hFFF5;
        step();
        release dut.score_r;
        for (int i = 0; i < 3; i++) begin
            do_frame(12'h040, 4'd1, 12'h040, 1'b0);
            do_frame(12'h000, 4'd1, 12'h000, 1'b0);
        end
        chk("sat.preload", 32'(score), 32'h0000FFFE);
        do_frame(12'h040, 4'd1, 12'h040, 1'b0);
        do_frame(12'h000, 4'd1, 12'h000, 1'b0);
        chk("sat.perfect", 32'(score), 32'h0000FFFF);
        do_frame(12'h100, 4'd2, 12'h000, 1'b0);
        do_frame(12'h100, 4'd2, 12'h100, 1'b0);
        do_frame(12'h000, 4'd1, 12'h000, 1'b0);
        chk_totals("sat.good", 65535, 11, 11);

        snap();
        do_frame(12'h002, 4'd2, 12'h000, 1'b0);
        frame_cnt   = 8'd0;
        game_frame  = 8'd0;
        curr_note   = 12'h000;
        hold_length = 4'd1;
        keys        = 12'h000;
        repeat (FRAME_LEN) step();
        chk_totals("restart", 0, 0, 11);
        chk_deltas("restart", 0, 0, 0);
        do_frame(12'h001, 4'd1, 12'h001, 1'b0);
        do_frame(12'h000, 4'd1, 12'h000, 1'b0);
        chk_totals("restart.after", 3, 1, 11);

        frame_cnt   = frame_cnt + 8'd1;
        game_frame  = frame_cnt;
        curr_note   = 12'h004;
        hold_length = 4'd1;
        for (int c = 0; c < 5; c++) begin
            keys = (c == 4) ? 12'h004 : 12'h000;
            step();
        end
        chk("pulse.hit",     32'(hit_pulse),     32'd1);
        chk("pulse.perfect", 32'(perfect_pulse), 32'd1);
        game_reset_n = 1'b0;
        keys         = 12'h000;
        #1;
        chk_totals("midreset", 0, 0, 0);
        chk("midreset.hit_pulse",     32'(hit_pulse),     32'd0);
        chk("midreset.perfect_pulse", 32'(perfect_pulse), 32'd0);
        chk("midreset.miss_pulse",    32'(miss_pulse),    32'd0);
        frame_cnt   = 8'd0;
        game_frame  = 8'd0;
        curr_note   = 12'h000;
        repeat (3) step();
        game_reset_n = 1'b1;
        step();

        m_score = 0;
        m_combo = 0;
        m_max   = 0;
        m_hit   = 0;
        m_perf  = 0;
        m_miss  = 0;
        snap();
        for (int w = 0; w < 40; w++) rand_window(w == 39);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
